// File: rtl/kmp_prefix_builder.sv
// KMP failure-table (LPS) builder: reads the pattern from a synchronous ROM, stores the table
// and serves it through a combinational read port. Optional macro KMP_BUILD_CYCLES_EN adds build_cycles.
module kmp_prefix_builder #(
    parameter int PAT_LEN = 5,
    parameter int ADDR_W  = 3,
    parameter int DATA_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [ADDR_W-1:0] pat_addr,
    input  logic [DATA_W-1:0] pat_data,
    output logic              busy,
    output logic              done,
    output logic              lps_valid,
    input  logic [ADDR_W-1:0] lps_rd_addr,
    output logic [ADDR_W-1:0] lps_rd_data
`ifdef KMP_BUILD_CYCLES_EN
    ,
    output logic [7:0]        build_cycles
`endif
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH_I = 3'd1,
        S_LATCH_I = 3'd2,
        S_FETCH_L = 3'd3,
        S_COMPARE = 3'd4,
        S_DONE    = 3'd5
    } state_e;

    localparam logic [ADDR_W:0] PAT_LEN_W = (ADDR_W+1)'(PAT_LEN);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] i_q, i_d;
    logic [ADDR_W-1:0] len_q, len_d;
    logic [DATA_W-1:0] pat_i_q, pat_i_d;
    logic              lps_valid_q, lps_valid_d;
    logic [ADDR_W-1:0] lps_q [PAT_LEN];
    logic [ADDR_W-1:0] lps_d [PAT_LEN];

    logic              lps_clr_s;
    logic              lps_we_s;
    logic [ADDR_W-1:0] lps_wval_s;
    logic [ADDR_W-1:0] len_prev_s;
    logic [ADDR_W-1:0] rd_s;
    logic [ADDR_W:0]   i_inc_s;
    logic              i_last_s;

    // Table lookups: fallback entry LPS[len-1] and the external read port
    always_comb begin
        len_prev_s = '0;
        rd_s       = '0;
        for (int k = 0; k < PAT_LEN; k++) begin
            len_prev_s = (ADDR_W'(k) == (len_q - ADDR_W'(1))) ? lps_q[k] : len_prev_s;
            rd_s       = (ADDR_W'(k) == lps_rd_addr) ? lps_q[k] : rd_s;
        end
        lps_rd_data = rd_s;
    end

    // FSM next-state, counters, table write request and ROM address decode
    always_comb begin
        state_d     = state_q;
        i_d         = i_q;
        len_d       = len_q;
        pat_i_d     = pat_i_q;
        lps_valid_d = lps_valid_q;
        lps_clr_s   = 1'b0;
        lps_we_s    = 1'b0;
        lps_wval_s  = '0;
        pat_addr    = '0;
        busy        = 1'b1;
        done        = 1'b0;
        i_inc_s     = {1'b0, i_q} + (ADDR_W+1)'(1);
        i_last_s    = (i_inc_s == PAT_LEN_W);
        case (state_q)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    lps_clr_s   = 1'b1;
                    i_d         = ADDR_W'(1);
                    len_d       = '0;
                    lps_valid_d = 1'b0;
                    state_d     = (PAT_LEN > 1) ? S_FETCH_I : S_DONE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FETCH_I: begin
                pat_addr = i_q;
                state_d  = S_LATCH_I;
            end
            S_LATCH_I: begin
                pat_i_d  = pat_data;
                pat_addr = len_q;
                state_d  = S_COMPARE;
            end
            S_FETCH_L: begin
                pat_addr = len_q;
                state_d  = S_COMPARE;
            end
            S_COMPARE: begin
                if (pat_data == pat_i_q) begin
                    lps_we_s   = 1'b1;
                    lps_wval_s = len_q + ADDR_W'(1);
                    len_d      = len_q + ADDR_W'(1);
                    i_d        = i_inc_s[ADDR_W-1:0];
                    state_d    = i_last_s ? S_DONE : S_FETCH_I;
                end else if (len_q != '0) begin
                    // pat_i_q is kept; only the prefix pointer retreats
                    len_d   = len_prev_s;
                    state_d = S_FETCH_L;
                end else begin
                    lps_we_s   = 1'b1;
                    lps_wval_s = '0;
                    i_d        = i_inc_s[ADDR_W-1:0];
                    state_d    = i_last_s ? S_DONE : S_FETCH_I;
                end
            end
            S_DONE: begin
                done        = 1'b1;
                lps_valid_d = 1'b1;
                state_d     = S_IDLE;
            end
            default: begin
                busy    = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // Table next-state: bulk clear on start, single-entry write from COMPARE
    always_comb begin
        for (int k = 0; k < PAT_LEN; k++) begin
            lps_d[k] = lps_clr_s ? '0 :
                       ((lps_we_s && (ADDR_W'(k) == i_q)) ? lps_wval_s : lps_q[k]);
        end
    end

    // State, counters and table registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            i_q         <= ADDR_W'(1);
            len_q       <= '0;
            pat_i_q     <= '0;
            lps_valid_q <= 1'b0;
            for (int k = 0; k < PAT_LEN; k++) begin
                lps_q[k] <= '0;
            end
        end else begin
            state_q     <= state_d;
            i_q         <= i_d;
            len_q       <= len_d;
            pat_i_q     <= pat_i_d;
            lps_valid_q <= lps_valid_d;
            lps_q       <= lps_d;
        end
    end

    assign lps_valid = lps_valid_q;

`ifdef KMP_BUILD_CYCLES_EN
    logic [7:0] cyc_q;

    // Saturating busy-cycle counter, cleared when a build is accepted
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cyc_q <= 8'd0;
        end else if ((state_q == S_IDLE) && start) begin
            cyc_q <= 8'd0;
        end else if (busy && (cyc_q != 8'hFF)) begin
            cyc_q <= cyc_q + 8'd1;
        end else begin
            cyc_q <= cyc_q;
        end
    end

    assign build_cycles = cyc_q;
`endif

endmodule

// File: tb/tb_kmp_prefix_builder.sv
// Self-checking bench for kmp_prefix_builder: directed and random patterns against a
// brute-force LPS reference, plus reset, start-while-busy and PAT_LEN=1 corner cases.
module tb_kmp_prefix_builder;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [2:0] pat_addr;
    logic [7:0] pat_data;
    logic       busy, done, lps_valid;
    logic [2:0] lps_rd_addr, lps_rd_data;

    logic       start1;
    logic [2:0] pat_addr1;
    logic [7:0] pat_data1;
    logic       busy1, done1, lps_valid1;
    logic [2:0] lps_rd_addr1, lps_rd_data1;
`ifdef KMP_BUILD_CYCLES_EN
    logic [7:0] build_cycles, build_cycles1;
`endif

    int total = 0;
    int bad   = 0;

    logic [7:0] rom [8];
    int         pat_m [8];
    int         lps_m [8];
    int         fb_m;

    always #5 clk = ~clk;

    always_ff @(posedge clk) pat_data  <= rom[pat_addr];
    always_ff @(posedge clk) pat_data1 <= 8'h41;

    kmp_prefix_builder #(.PAT_LEN(5), .ADDR_W(3), .DATA_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .pat_addr(pat_addr), .pat_data(pat_data),
        .busy(busy), .done(done), .lps_valid(lps_valid),
        .lps_rd_addr(lps_rd_addr), .lps_rd_data(lps_rd_data)
`ifdef KMP_BUILD_CYCLES_EN
        , .build_cycles(build_cycles)
`endif
    );

    kmp_prefix_builder #(.PAT_LEN(1), .ADDR_W(3), .DATA_W(8)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .pat_addr(pat_addr1), .pat_data(pat_data1),
        .busy(busy1), .done(done1), .lps_valid(lps_valid1),
        .lps_rd_addr(lps_rd_addr1), .lps_rd_data(lps_rd_data1)
`ifdef KMP_BUILD_CYCLES_EN
        , .build_cycles(build_cycles1)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: LPS by direct definition, fallbacks by walking the prefix chain
    task automatic model();
        int len;
        bit m;
        fb_m = 0;
        for (int i = 0; i < 5; i++) begin
            lps_m[i] = 0;
            for (int k = 1; k <= i; k++) begin
                m = 1'b1;
                for (int j = 0; j < k; j++)
                    if (pat_m[j] != pat_m[i-k+1+j]) m = 1'b0;
                if (m) lps_m[i] = k;
            end
        end
        for (int i = 1; i < 5; i++) begin
            len = lps_m[i-1];
            while (len > 0 && pat_m[i] != pat_m[len]) begin
                len = lps_m[len-1];
                fb_m++;
            end
        end
    endtask

    task automatic load(input string s);
        for (int k = 0; k < 5; k++) begin
            rom[k]   = s[k];
            pat_m[k] = int'(s[k]);
        end
        model();
    endtask

    task automatic build(input bit noisy, input string nm);
        int dc;
        int exp_cyc;
        dc = -1;
        exp_cyc = 3 * 4 + 2 * fb_m + 1;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (done) begin
                dc = c;
                break;
            end
            start = (noisy && (c == 2 || c == 6)) ? 1'b1 : 1'b0;
        end
        chk({nm, "_done_cycle"}, dc, exp_cyc);
        start = noisy;
        @(negedge clk);
        start = 1'b0;
        chk({nm, "_done_width"}, done, 1'b0);
        chk({nm, "_busy_after"}, busy, 1'b0);
        chk({nm, "_lps_valid"}, lps_valid, 1'b1);
`ifdef KMP_BUILD_CYCLES_EN
        chk({nm, "_build_cycles"}, build_cycles, exp_cyc);
`endif
        for (int a = 0; a < 8; a++) begin
            lps_rd_addr = 3'(a);
            #1;
            chk($sformatf("%s_lps%0d", nm, a), lps_rd_data, (a < 5) ? lps_m[a] : 0);
        end
    endtask

    initial begin
        string s;
        rst = 1'b0;
        start = 1'b0;
        start1 = 1'b0;
        lps_rd_addr = 3'd0;
        lps_rd_addr1 = 3'd0;
        for (int k = 0; k < 8; k++) rom[k] = 8'h00;
        #12;
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_valid", lps_valid, 1'b0);
        chk("rst_pat_addr", pat_addr, 3'd0);
        chk("rst_rd", lps_rd_data, 3'd0);
        chk("rst_valid1", lps_valid1, 1'b0);
        @(negedge clk);
        rst = 1'b1;

        load("ABCDE"); build(1'b1, "abcde");
        load("AAAAA"); build(1'b0, "aaaaa");
        load("ABABC"); build(1'b0, "ababc");
        load("AAABA"); build(1'b1, "aaaba");

        // Reset during cycle 5 of an ABABC build
        load("ABABC");
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(negedge clk);
        chk("mid_busy_pre", busy, 1'b1);
        rst = 1'b0;
        #1;
        chk("mid_busy", busy, 1'b0);
        chk("mid_valid", lps_valid, 1'b0);
        chk("mid_pat_addr", pat_addr, 3'd0);
        for (int a = 0; a < 8; a++) begin
            lps_rd_addr = 3'(a);
            #1;
            chk($sformatf("mid_lps%0d", a), lps_rd_data, 3'd0);
        end
        @(negedge clk);
        rst = 1'b1;
        build(1'b0, "restart");

        for (int r = 0; r < 6; r++) begin
            s = "AAAAA";
            for (int k = 0; k < 5; k++) s[k] = 8'h41 + 8'($urandom_range(0, 1));
            load(s);
            build(r[0], $sformatf("rnd%0d_%s", r, s));
        end

        // PAT_LEN = 1 instance
        @(negedge clk);
        start1 = 1'b1;
        @(posedge clk);
        #1 start1 = 1'b0;
        @(negedge clk);
        chk("len1_done", done1, 1'b1);
        chk("len1_pat_addr", pat_addr1, 3'd0);
        @(negedge clk);
        chk("len1_done_width", done1, 1'b0);
        chk("len1_busy", busy1, 1'b0);
        chk("len1_valid", lps_valid1, 1'b1);
        chk("len1_lps0", lps_rd_data1, 3'd0);
`ifdef KMP_BUILD_CYCLES_EN
        chk("len1_build_cycles", build_cycles1, 8'd1);
`endif
        lps_rd_addr1 = 3'd3;
        #1;
        chk("len1_oob", lps_rd_data1, 3'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/kmp_prefix_builder.md
Name: kmp_prefix_builder

Overview:
- Preprocessing companion to the KMP matcher.
- Reads the pattern from the same synchronous pattern ROM and computes the KMP failure table (longest proper prefix that is also a suffix, LPS).
- Stores the table internally and serves it to the matcher through a combinational read port.
- The matcher consumes lps_rd_data on mismatches instead of restarting the pattern at address 0.

Parameters:
- PAT_LEN, 5: pattern length in characters; ROM addresses 0..PAT_LEN-1; legal range 1..2**ADDR_W.
- ADDR_W, 3: width of the pattern address, the LPS entries and the internal i/len counters.
- DATA_W, 8: character width.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- start  in  1  begin a table build; sampled in IDLE only
- pat_addr  out  ADDR_W  pattern ROM address; ROM returns data one cycle later
- pat_data  in  DATA_W  pattern ROM read data
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when the table is complete
- lps_valid  out  1  table contents valid; held until the next start or reset
- lps_rd_addr  in  ADDR_W  table read index, driven by the matcher
- lps_rd_data  out  ADDR_W  LPS[lps_rd_addr], combinational; 0 when lps_rd_addr >= PAT_LEN

Behaviour:
- Reset (rst=0, async):
  - State IDLE; i=1, len=0, pat_i_q=0, all LPS entries 0.
  - busy=0, done=0, lps_valid=0, pat_addr=0.
- State IDLE:
  - start=1 clears all LPS entries, sets i=1, len=0, lps_valid=0.
  - Next state: FETCH_I if PAT_LEN>1, else DONE.
- State FETCH_I: pat_addr=i. Next state LATCH_I.
- State LATCH_I: pat_i_q<=pat_data (this is pat[i]); pat_addr=len. Next state COMPARE.
- State FETCH_L: pat_addr=len. Next state COMPARE. Entered only after a fallback; pat_i_q is unchanged.
- State COMPARE (pat_data holds pat[len]):
  - Match (pat_data==pat_i_q): LPS[i]<=len+1; len<=len+1; i<=i+1.
  - Mismatch with len!=0: len<=LPS[len-1]; next state FETCH_L; i unchanged.
  - Mismatch with len==0: LPS[i]<=0; i<=i+1.
  - After any i increment: next state DONE if the new i==PAT_LEN, else FETCH_I.
- State DONE: done=1 for exactly one cycle; lps_valid<=1. Next state IDLE.
- pat_addr is a combinational decode of state/i/len; 0 in IDLE and DONE.
- LPS[0] is always 0. No entry exceeds PAT_LEN-1. len never exceeds i, so no overflow at ADDR_W.
- Latency:
  - Non-repeating pattern: 3 cycles per index i=1..PAT_LEN-1, then DONE.
  - Each fallback adds 2 cycles.
  - PAT_LEN=5, all distinct: done is high in cycle 13 after the start edge.
- start while busy: ignored, no restart.
- start in the same cycle as done: ignored (FSM is in DONE, not IDLE).
- Reset mid-build: immediate return to reset values; a partially built table is discarded; lps_valid stays 0.
- lps_rd_data is readable at any time. The consumer must qualify it with lps_valid.

Optional Feature:
- Macro: KMP_BUILD_CYCLES_EN.
- With the macro defined:
  - Extra output port build_cycles, 8 bits.
  - Counts cycles while busy=1, saturating at 255.
  - Cleared on start accepted in IDLE and on reset.
  - Holds its value after DONE until the next start.
- Without the macro: the port and counter do not exist; all other behaviour is identical.

Test Plan:
- ROM "ABCDE", pulse start:
  - LPS = 0,0,0,0,0.
  - done pulses in cycle 13 after the start edge, one cycle wide.
  - busy drops the cycle after done; lps_valid=1.
- ROM "AAAAA": LPS = 0,1,2,3,4; no FETCH_L visits; done in cycle 13.
- ROM "ABABC":
  - LPS = 0,0,1,2,0.
  - The C mismatch falls back len 2->0 through FETCH_L (2 extra cycles).
  - done in cycle 15.
- ROM "AAABA":
  - LPS = 0,1,2,0,1 (fallback chain len 2->1->0 at index 3).
  - With KMP_BUILD_CYCLES_EN: build_cycles = 17.
- Reset and start corner cases:
  - Assert rst=0 during cycle 5 of an "ABABC" build: busy=0, lps_valid=0 and all entries read 0 immediately.
  - Restart after reset produces the correct table.
  - start pulses during busy are ignored.
- Read port and minimum length:
  - lps_rd_addr=5..7: lps_rd_data=0.
  - PAT_LEN=1: start leads to DONE on the next cycle; LPS[0]=0, lps_valid=1.
